// File: rtl/conv_pkg.sv
// Shared widths and helpers for the signed/unsigned multiply converter.
`timescale 1ns/1ps
package conv_pkg;

  localparam int unsigned ROM_IDX_W = 5;
  localparam int unsigned ROM_OUT_W = 10;
  localparam int unsigned OP_W      = 8;
  localparam int unsigned RES_W     = 16;
  localparam int unsigned FAT_W     = 2 * ROM_IDX_W;
  localparam int unsigned ROM_DEPTH = 1 << FAT_W;

  // Magnitude of a two's-complement operand; -128 maps to 8'h80 by wraparound.
  function automatic logic [OP_W-1:0] conv_mag(input logic [OP_W-1:0] v);
    return v[OP_W-1] ? OP_W'(~v + 1'b1) : v;
  endfunction

  function automatic logic [RES_W-1:0] conv_sign(input logic [RES_W-1:0] v, input logic n);
    return n ? RES_W'(~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/rom_mult5x5.sv
// 5x5-bit product lookup table; CONV_ROM_REGISTERED_EN adds an output register.
`timescale 1ns/1ps
module rom_mult5x5
  import conv_pkg::*;
(
`ifdef CONV_ROM_REGISTERED_EN
  input  logic                 clock,
  input  logic                 reset,
`endif
  input  logic [FAT_W-1:0]     Fatores,
  output logic [ROM_OUT_W-1:0] Produto
);

  logic [ROM_OUT_W-1:0] rom [ROM_DEPTH];

  // Table contents are constants: entry {x,y} holds x*y.
  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
    assign rom[i] = ROM_OUT_W'((i / (1 << ROM_IDX_W)) * (i % (1 << ROM_IDX_W)));
  end

`ifdef CONV_ROM_REGISTERED_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) Produto <= '0;
    else        Produto <= rom[Fatores];
  end
`else
  assign Produto = rom[Fatores];
`endif

endmodule

// File: rtl/conversor_unsigned.sv
// Converts signed operands to magnitudes and re-signs the unsigned product.
// Optional macro CONV_ROM_REGISTERED_EN registers the product-table output.
`timescale 1ns/1ps
module conversor_unsigned
  import conv_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [OP_W-1:0]      A,
  input  logic [OP_W-1:0]      B,
  output logic [OP_W-1:0]      AUnsigned,
  output logic [OP_W-1:0]      BUnsigned,
  output logic                 neg,
  input  logic                 res_valid,
  input  logic [RES_W-1:0]     RES,
  output logic [RES_W-1:0]     RESFINAL,
  output logic                 final_valid,
  input  logic [FAT_W-1:0]     Fatores,
  output logic [ROM_OUT_W-1:0] Produto
);

  // RES is re-signed with the sign held before this edge, so a same-edge load
  // only affects the next conversion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      AUnsigned   <= '0;
      BUnsigned   <= '0;
      neg         <= 1'b0;
      RESFINAL    <= '0;
      final_valid <= 1'b0;
    end else begin
      final_valid <= res_valid;
      if (res_valid) RESFINAL <= conv_sign(RES, neg);
      if (load) begin
        AUnsigned <= conv_mag(A);
        BUnsigned <= conv_mag(B);
        neg       <= A[OP_W-1] ^ B[OP_W-1];
      end
    end
  end

  rom_mult5x5 u_rom (
`ifdef CONV_ROM_REGISTERED_EN
    .clock   (clock),
    .reset   (reset),
`endif
    .Fatores (Fatores),
    .Produto (Produto)
  );

endmodule

// File: tb/tb_conversor_unsigned.sv
// Self-checking bench for conversor_unsigned: vector table, hand sequences, random vs model.
`timescale 1ns/1ps
module tb_conversor_unsigned;

  logic        clock = 1'b0;
  logic        reset;
  logic        load;
  logic [7:0]  A, B;
  logic [7:0]  AUnsigned, BUnsigned;
  logic        neg;
  logic        res_valid;
  logic [15:0] RES;
  logic [15:0] RESFINAL;
  logic        final_valid;
  logic [9:0]  Fatores;
  logic [9:0]  Produto;

  int n_pass = 0;
  int n_total = 0;

  int m_aun, m_bun, m_neg, m_rf, m_fv, m_prod;

  always #5 clock = ~clock;

  conversor_unsigned dut (
    .clock(clock), .reset(reset), .load(load), .A(A), .B(B),
    .AUnsigned(AUnsigned), .BUnsigned(BUnsigned), .neg(neg),
    .res_valid(res_valid), .RES(RES), .RESFINAL(RESFINAL),
    .final_valid(final_valid), .Fatores(Fatores), .Produto(Produto)
  );

  typedef struct {
    logic [7:0]  a, b;
    logic [15:0] res;
    int          aun, bun, ng, rf;
  } vec_t;

  function automatic int mag(input logic [7:0] v);
    int s;
    s = int'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  function automatic int prod_of(input logic [9:0] f);
    return (int'(f) / 32) * (int'(f) % 32);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Advance one edge, updating the reference model from the inputs applied at it.
  task automatic tick();
    if (!reset) begin
      m_aun = 0; m_bun = 0; m_neg = 0; m_rf = 0; m_fv = 0;
    end else begin
      m_fv = int'(res_valid);
      if (res_valid) m_rf = m_neg ? (65536 - int'(RES)) % 65536 : int'(RES);
      if (load) begin
        m_aun = mag(A); m_bun = mag(B); m_neg = int'(A[7] ^ B[7]);
      end
    end
    m_prod = reset ? prod_of(Fatores) : 0;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".aun"}, 32'(AUnsigned), 32'(m_aun));
    chk({tag, ".bun"}, 32'(BUnsigned), 32'(m_bun));
    chk({tag, ".neg"}, 32'(neg), 32'(m_neg));
    chk({tag, ".rf"},  32'(RESFINAL), 32'(m_rf));
    chk({tag, ".fv"},  32'(final_valid), 32'(m_fv));
  endtask

  task automatic chk_prod(input logic [9:0] f, input int exp);
    Fatores = f;
`ifdef CONV_ROM_REGISTERED_EN
    #1;
    chk("prod_not_yet", 32'(Produto), 32'(m_prod));
    tick();
`else
    #1;
`endif
    chk("prod", 32'(Produto), 32'(exp));
  endtask

  vec_t vecs[5];

  initial begin
    reset = 1'b0; load = 1'b0; res_valid = 1'b0;
    A = '0; B = '0; RES = '0; Fatores = '0;
    m_aun = 0; m_bun = 0; m_neg = 0; m_rf = 0; m_fv = 0; m_prod = 0;
    #2;
    chk("rst_aun", 32'(AUnsigned), 0);
    chk("rst_bun", 32'(BUnsigned), 0);
    chk("rst_neg", 32'(neg), 0);
    chk("rst_rf",  32'(RESFINAL), 0);
    chk("rst_fv",  32'(final_valid), 0);
`ifdef CONV_ROM_REGISTERED_EN
    chk("rst_prod", 32'(Produto), 0);
`endif
    tick();
    reset = 1'b1;

    vecs[0] = '{8'hFD, 8'h05, 16'd15,    3,   5,   1, 16'hFFF1};
    vecs[1] = '{8'h80, 8'h80, 16'h4000,  128, 128, 0, 16'h4000};
    vecs[2] = '{8'h00, 8'hF9, 16'd0,     0,   7,   1, 0};
    vecs[3] = '{8'h7F, 8'h81, 16'd16129, 127, 127, 1, 16'hC0FF};
    vecs[4] = '{8'h10, 8'h20, 16'd512,   16,  32,  0, 512};

    foreach (vecs[i]) begin
      load = 1'b1; A = vecs[i].a; B = vecs[i].b;
      tick();
      load = 1'b0;
      chk($sformatf("v%0d.aun", i), 32'(AUnsigned), 32'(vecs[i].aun));
      chk($sformatf("v%0d.bun", i), 32'(BUnsigned), 32'(vecs[i].bun));
      chk($sformatf("v%0d.neg", i), 32'(neg), 32'(vecs[i].ng));
      chk($sformatf("v%0d.fv0", i), 32'(final_valid), 0);
      res_valid = 1'b1; RES = vecs[i].res;
      tick();
      res_valid = 1'b0;
      chk($sformatf("v%0d.rf", i), 32'(RESFINAL), 32'(vecs[i].rf));
      chk($sformatf("v%0d.fv1", i), 32'(final_valid), 1);
      RES = 16'h1234;
      tick();
      chk($sformatf("v%0d.fv_drop", i), 32'(final_valid), 0);
      chk($sformatf("v%0d.rf_hold", i), 32'(RESFINAL), 32'(vecs[i].rf));
    end

    // Same-edge load and res_valid: old sign converts, new sign applies next.
    load = 1'b1; A = 8'h01; B = 8'h01;
    tick();
    chk("same.neg0", 32'(neg), 0);
    A = 8'hFF; B = 8'h01; res_valid = 1'b1; RES = 16'd9;
    tick();
    load = 1'b0;
    chk("same.rf", 32'(RESFINAL), 9);
    chk("same.neg1", 32'(neg), 1);
    tick();
    res_valid = 1'b0;
    chk("same.rf2", 32'(RESFINAL), 16'hFFF7);
    tick();

    // Product table, including the maximum and a zero factor.
    chk_prod({5'd31, 5'd31}, 961);
    chk_prod({5'd12, 5'd0}, 0);
    chk_prod({5'd5, 5'd7}, 35);

    // Reset mid-operation: outputs clear at once and the pending pulse is lost.
    load = 1'b1; A = 8'hFD; B = 8'h05;
    tick();
    load = 1'b0; res_valid = 1'b1; RES = 16'd15;
    #2;
    reset = 1'b0;
    #1;
    chk("arst.aun", 32'(AUnsigned), 0);
    chk("arst.neg", 32'(neg), 0);
    chk("arst.rf",  32'(RESFINAL), 0);
    chk("arst.fv",  32'(final_valid), 0);
`ifdef CONV_ROM_REGISTERED_EN
    chk("arst.prod", 32'(Produto), 0);
`endif
    m_aun = 0; m_bun = 0; m_neg = 0; m_rf = 0; m_fv = 0; m_prod = 0;
    tick();
    chk("arst.fv_edge", 32'(final_valid), 0);
    reset = 1'b1; res_valid = 1'b0;
    tick();
    chk_model("arst.after");
    load = 1'b1; A = 8'hFA; B = 8'h03;
    tick();
    load = 1'b0;
    chk("post.aun", 32'(AUnsigned), 6);
    chk("post.neg", 32'(neg), 1);

    // Random traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      load      = 1'($urandom_range(0, 1));
      res_valid = 1'($urandom_range(0, 1));
      A         = 8'($urandom);
      B         = 8'($urandom);
      RES       = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      Fatores   = 10'($urandom);
`ifndef CONV_ROM_REGISTERED_EN
      #1;
      chk("rnd.prod", 32'(Produto), 32'(prod_of(Fatores)));
`endif
      tick();
      chk_model($sformatf("rnd%0d", i));
`ifdef CONV_ROM_REGISTERED_EN
      chk("rnd.prod", 32'(Produto), 32'(m_prod));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
